// File: rtl/aes_sbox_pkg.sv
// rtl/aes_sbox_pkg.sv - shared constants, state enum and GF(2^8)/affine helpers for the S-box datapath
//
// Purpose: affine constants, the sequencer state enum, rotl8, the forward and
// inverse affine maps, and GF(2^8) multiply/inverse over x^8+x^4+x^3+x+1.
package aes_sbox_pkg;

    localparam logic [7:0] AFF_FWD_C = 8'h63;
    localparam logic [7:0] AFF_INV_C = 8'h05;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] w;
        w = {x, x} << n;
        return w[15:8];
    endfunction

    function automatic logic [7:0] aff_fwd(input logic [7:0] s);
        return s ^ rotl8(s, 3'd1) ^ rotl8(s, 3'd2) ^ rotl8(s, 3'd3) ^ rotl8(s, 3'd4) ^ AFF_FWD_C;
    endfunction

    function automatic logic [7:0] aff_inv(input logic [7:0] x);
        return rotl8(x, 3'd1) ^ rotl8(x, 3'd3) ^ rotl8(x, 3'd6) ^ AFF_INV_C;
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 = x^(2+4+...+128); yields 0 for x = 0 without a special case.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] p;
        logic [7:0] r;
        p = x;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

endpackage

// File: rtl/gf_mulinv_8.sv
// rtl/gf_mulinv_8.sv - combinational GF(2^8) multiplicative inverse
//
// Ports: a_i (byte in), inv_o (inverse of a_i, 0 maps to 0).
module gf_mulinv_8
    import aes_sbox_pkg::*;
(
    input  logic [7:0] a_i,
    output logic [7:0] inv_o
);

    assign inv_o = gf_inv(a_i);

endmodule

// File: rtl/sbox_lane.sv
// rtl/sbox_lane.sv - one forward/inverse S-box lane with optional internal pipeline register
//
// Ports: CLK (clock for the optional stage), x (byte in), dec (1 = inverse
// S-box), y (substituted byte). With PIPE=1, y lags x/dec by one cycle.
module sbox_lane
    import aes_sbox_pkg::*;
#(
    parameter int PIPE = 0
) (
    input  logic       CLK,
    input  logic [7:0] x,
    input  logic       dec,
    output logic [7:0] y
);

    logic [7:0] pre;
    logic [7:0] inv;
    logic [7:0] s_q;
    logic       dec_q;
    logic [7:0] s_sel;
    logic       dec_sel;

    // Inverse S-box runs the inverse affine map before the field inverse.
    assign pre = dec ? aff_inv(x) : x;

    gf_mulinv_8 u_inv (
        .a_i   (pre),
        .inv_o (inv)
    );

    // Pure datapath stage; validity is tracked by the parent, so no reset.
    always_ff @(posedge CLK) begin
        s_q   <= inv;
        dec_q <= dec;
    end

    assign s_sel   = (PIPE != 0) ? s_q   : inv;
    assign dec_sel = (PIPE != 0) ? dec_q : dec;

    // Forward S-box applies the forward affine map after the field inverse.
    assign y = dec_sel ? s_sel : aff_fwd(s_sel);

endmodule

// File: rtl/sub_bytes_seq.sv
// rtl/sub_bytes_seq.sv - sequential SubBytes over a 128-bit state using LANES S-box lanes
//
// Ports:
//   CLK, RST              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_dec and in_data sampled on accept
//   in_dec                0 = forward S-box, 1 = inverse S-box
//   in_data[127:0]        input state, byte 0 in bits [127:120]
//   out_valid/out_ready   output handshake; out_data held while out_valid=1
//   out_data[127:0]       substituted state, same byte order
module sub_bytes_seq
    import aes_sbox_pkg::*;
#(
    parameter int LANES = 4,
    parameter int PIPE  = 0
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         in_dec,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);

    localparam int BEATS = 16 / LANES;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
        $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
    if (!(PIPE == 0 || PIPE == 1)) begin : g_bad_pipe
        $error("sub_bytes_seq: PIPE must be 0 or 1");
    end

    state_e        state_q;
    logic [CW-1:0] beat_q;        // group currently fed into the lanes
    logic [CW-1:0] wbeat_q;       // group held in the lane pipeline registers
    logic          pv_q;          // lane pipeline registers hold a live group
    logic          issue_done_q;  // every group has been fed into the lanes
    logic          dec_q;
    logic [127:0]  in_q;
    logic [127:0]  out_q;
    logic          out_valid_q;

    logic [7:0]    lane_x [LANES];
    logic [7:0]    lane_y [LANES];
    logic [127:0]  out_d;
    logic [CW-1:0] widx;
    logic          wr_en;
    logic          last_wr;
    logic          issuing;

    assign in_ready  = !RST && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
    assign out_valid = out_valid_q;
    assign out_data  = out_q;

    // With PIPE=1 the results written this cycle belong to the group issued
    // last cycle, so the write side uses its own index and valid.
    assign issuing = (state_q == BUSY) && !issue_done_q;
    assign widx    = (PIPE != 0) ? wbeat_q : beat_q;
    assign wr_en   = (state_q == BUSY) && ((PIPE != 0) ? pv_q : 1'b1);
    assign last_wr = wr_en && (widx == LAST_BEAT);

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_x[l] = in_q[7'(8 * (15 - (int'(beat_q) * LANES + l))) +: 8];
        end
    end

    always_comb begin
        out_d = out_q;
        for (int l = 0; l < LANES; l++) begin
            out_d[7'(8 * (15 - (int'(widx) * LANES + l))) +: 8] = lane_y[l];
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        sbox_lane #(.PIPE(PIPE)) u_lane (
            .CLK (CLK),
            .x   (lane_x[l]),
            .dec (dec_q),
            .y   (lane_y[l])
        );
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= IDLE;
            beat_q       <= '0;
            wbeat_q      <= '0;
            pv_q         <= 1'b0;
            issue_done_q <= 1'b0;
            dec_q        <= 1'b0;
            in_q         <= '0;
            out_q        <= '0;
            out_valid_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_q         <= in_data;
                        dec_q        <= in_dec;
                        beat_q       <= '0;
                        pv_q         <= 1'b0;
                        issue_done_q <= 1'b0;
                        state_q      <= BUSY;
                    end
                end
                BUSY: begin
                    pv_q    <= issuing;
                    wbeat_q <= beat_q;
                    if (issuing) begin
                        if (beat_q == LAST_BEAT) begin
                            issue_done_q <= 1'b1;
                        end else begin
                            beat_q <= beat_q + 1'b1;
                        end
                    end
                    if (wr_en) begin
                        out_q <= out_d;
                    end
                    if (last_wr) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            in_q         <= in_data;
                            dec_q        <= in_dec;
                            beat_q       <= '0;
                            pv_q         <= 1'b0;
                            issue_done_q <= 1'b0;
                            state_q      <= BUSY;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_seq.sv
// tb/tb_sub_bytes_seq.sv - directed self-checking bench for sub_bytes_seq across all LANES/PIPE settings
module tb_sub_bytes_seq;

    localparam int NCFG = 10;  // cfg g: LANES = 1 << (g/2), PIPE = g % 2

    localparam logic [127:0] FIPS_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
    localparam logic [127:0] FIPS_OUT = 128'hd42711aee0bf98f1b8b45de51e415230;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid  [NCFG];
    logic         in_ready  [NCFG];
    logic         in_dec    [NCFG];
    logic [127:0] in_data   [NCFG];
    logic         out_valid [NCFG];
    logic         out_ready [NCFG];
    logic [127:0] out_data  [NCFG];

    logic [127:0] sbox_rows [16];

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        sub_bytes_seq #(.LANES(1 << (g / 2)), .PIPE(g % 2)) u_dut (
            .CLK       (clk),
            .RST       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_dec    (in_dec[g]),
            .in_data   (in_data[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic send(input int g, input logic dec, input logic [127:0] d);
        @(negedge clk);
        in_valid[g] = 1'b1;
        in_dec[g]   = dec;
        in_data[g]  = d;
        @(posedge clk);
        #1;
        in_valid[g] = 1'b0;
        // Junk after the accept must not disturb the block in flight.
        in_dec[g]   = ~dec;
        in_data[g]  = ~d;
    endtask

    task automatic wait_out(input int g, output int lat);
        lat = 0;
        while (!out_valid[g] && lat < 64) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic pop(input int g);
        @(negedge clk);
        out_ready[g] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[g] = 1'b0;
    endtask

    task automatic run(input int g, input logic dec, input logic [127:0] d,
                       output logic [127:0] res, output int lat);
        send(g, dec, d);
        wait_out(g, lat);
        res = out_data[g];
        pop(g);
    endtask

    initial begin
        sbox_rows[0]  = 128'h637c777bf26b6fc53001672bfed7ab76;
        sbox_rows[1]  = 128'hca82c97dfa5947f0add4a2af9ca472c0;
        sbox_rows[2]  = 128'hb7fd9326363ff7cc34a5e5f171d83115;
        sbox_rows[3]  = 128'h04c723c31896059a071280e2eb27b275;
        sbox_rows[4]  = 128'h09832c1a1b6e5aa0523bd6b329e32f84;
        sbox_rows[5]  = 128'h53d100ed20fcb15b6acbbe394a4c58cf;
        sbox_rows[6]  = 128'hd0efaafb434d338545f9027f503c9fa8;
        sbox_rows[7]  = 128'h51a3408f929d38f5bcb6da2110fff3d2;
        sbox_rows[8]  = 128'hcd0c13ec5f974417c4a77e3d645d1973;
        sbox_rows[9]  = 128'h60814fdc222a908846eeb814de5e0bdb;
        sbox_rows[10] = 128'he0323a0a4906245cc2d3ac629195e479;
        sbox_rows[11] = 128'he7c8376d8dd54ea96c56f4ea657aae08;
        sbox_rows[12] = 128'hba78252e1ca6b4c6e8dd741f4bbd8b8a;
        sbox_rows[13] = 128'h703eb5664803f60e613557b986c11d9e;
        sbox_rows[14] = 128'he1f8981169d98e949b1e87e9ce5528df;
        sbox_rows[15] = 128'h8ca1890dbfe6426841992d0fb054bb16;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] res;
        logic [127:0] din;
        logic [127:0] dexp;
        logic [7:0]   cb_in  [6];
        logic [7:0]   cb_out [6];
        int           lat;

        cb_in[0] = 8'h00; cb_out[0] = 8'h63;
        cb_in[1] = 8'h01; cb_out[1] = 8'h7c;
        cb_in[2] = 8'h53; cb_out[2] = 8'hed;
        cb_in[3] = 8'hff; cb_out[3] = 8'h16;
        cb_in[4] = 8'h63; cb_out[4] = 8'h00;
        cb_in[5] = 8'h16; cb_out[5] = 8'hff;

        rst = 1'b1;
        for (int g = 0; g < NCFG; g++) begin
            in_valid[g]  = 1'b0;
            in_dec[g]    = 1'b0;
            in_data[g]   = '0;
            out_ready[g] = 1'b0;
        end

        // Reset behaviour.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready_low", in_ready[4], 1'b0);
        chk("rst_out_valid_low", out_valid[4], 1'b0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_in_ready", in_ready[4], 1'b1);
        chk("post_rst_out_valid", out_valid[4], 1'b0);
        chk("post_rst_out_data", out_data[4], 128'h0);

        // FIPS-197 round-1 SubBytes, forward, LANES=4 PIPE=0.
        run(4, 1'b0, FIPS_IN, res, lat);
        chk("fips_fwd_data", res, FIPS_OUT);
        chk("fips_fwd_latency", lat, 4);

        // Inverse on every configuration.
        for (int g = 0; g < NCFG; g++) begin
            run(g, 1'b1, FIPS_OUT, res, lat);
            chk($sformatf("inv_cfg%0d_data", g), res, FIPS_IN);
            chk($sformatf("inv_cfg%0d_latency", g), lat, (16 >> (g / 2)) + (g % 2));
        end

        // Corner bytes, all 16 bytes equal, LANES=1.
        for (int i = 0; i < 6; i++) begin
            run(0, (i >= 4) ? 1'b1 : 1'b0, {16{cb_in[i]}}, res, lat);
            chk($sformatf("corner_%0d_data", i), res, {16{cb_out[i]}});
        end

        // Backpressure then back-to-back accept on the releasing edge.
        send(4, 1'b0, FIPS_IN);
        wait_out(4, lat);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_data_c%0d", c), out_data[4], FIPS_OUT);
            chk($sformatf("bp_valid_c%0d", c), out_valid[4], 1'b1);
            chk($sformatf("bp_in_ready_c%0d", c), in_ready[4], 1'b0);
        end
        @(negedge clk);
        out_ready[4] = 1'b1;
        in_valid[4]  = 1'b1;
        in_dec[4]    = 1'b1;
        in_data[4]   = FIPS_OUT;
        #1;
        chk("b2b_in_ready", in_ready[4], 1'b1);
        @(posedge clk);
        #1;
        in_valid[4]  = 1'b0;
        out_ready[4] = 1'b0;
        in_dec[4]    = 1'b0;
        chk("b2b_valid_drop", out_valid[4], 1'b0);
        wait_out(4, lat);
        chk("b2b_second_data", out_data[4], FIPS_IN);
        chk("b2b_second_latency", lat, 4);
        pop(4);

        // Reset at beat 2 on LANES=2, then a clean block.
        send(2, 1'b0, FIPS_IN);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", out_valid[2], 1'b0);
        chk("midrst_out_data", out_data[2], 128'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready[2], 1'b1);
        run(2, 1'b0, FIPS_IN, res, lat);
        chk("midrst_next_data", res, FIPS_OUT);
        chk("midrst_next_latency", lat, 8);

        // Exhaustive table sweep on LANES=16 PIPE=1.
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                din[127 - 8 * c -: 8] = 8'(16 * r + c);
            end
            dexp = sbox_rows[r];
            run(9, 1'b0, din, res, lat);
            chk($sformatf("sweep_fwd_row%0d", r), res, dexp);
            run(9, 1'b1, dexp, res, lat);
            chk($sformatf("sweep_inv_row%0d", r), res, din);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sub_bytes_seq.md
# sub_bytes_seq

Sequential, parametrised SubBytes engine for the composite-field AES datapath. It applies the forward or inverse AES S-box to a full 128-bit state through LANES parallel S-box lanes over 16/LANES beats, with an optional internal pipeline stage. Input and output use valid/ready handshakes. It sits between the round-key adder and ShiftRows in the iterative round loop, and replaces the fixed 32-bit combinational SubBytes where area versus throughput must be tunable.

## Interface
- LANES, 4, number of S-box lanes; legal values 1, 2, 4, 8, 16; any other value is an elaboration error
- PIPE, 0, 1 inserts a register between the GF inverse and the output affine stage
- CLK  in  1  single clock; all state updates on the rising edge
- RST  in  1  reset; synchronous and active-high
- in_valid  in  1  input state valid
- in_ready  out  1  block can accept an input state
- in_dec  in  1  0 = forward S-box (encrypt), 1 = inverse S-box (decrypt); sampled with the input state
- in_data  in  128  input state; byte 0 = in_data[127:120]
- out_valid  out  1  result held on out_data
- out_ready  in  1  downstream accepts the result
- out_data  out  128  substituted state, same byte order as in_data

## Operation
- BEATS = 16/LANES. Beat k processes bytes k·LANES … k·LANES+LANES−1, starting from the MSB group.
- Lane function, forward: s = GF_inv(x), then y = s ^ rotl(s,1) ^ rotl(s,2) ^ rotl(s,3) ^ rotl(s,4) ^ 0x63.
- Lane function, inverse: t = rotl(x,1) ^ rotl(x,3) ^ rotl(x,6) ^ 0x05, then y = GF_inv(t).
- GF_inv(0) = 0.
- States:
  - IDLE: in_ready=1. On in_valid: capture in_data and in_dec, clear the beat counter, go to BUSY.
  - BUSY: one beat per cycle; each lane result is written into its byte slot of the out_data register. After the last result is written (including the PIPE drain cycle when PIPE=1), go to DONE.
  - DONE: out_valid=1; out_data and the mode bit are held stable.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: accept the new state in the same cycle and go to BUSY (back-to-back).
- in_ready = IDLE | (DONE & out_ready). in_ready is low throughout BUSY.
- in_data and in_dec are ignored unless the handshake fires.
- The beat counter width is clog2(BEATS), minimum 1. It never wraps past BEATS−1 within a block.

## Timing
- Reset values: in_ready=0 during the reset cycle and 1 the cycle after; out_valid=0; out_data=0; state=IDLE; beat counter=0.
- Latency: out_valid rises BEATS+PIPE clock edges after the accepting edge.
  - LANES=4, PIPE=0: 4 edges.
  - LANES=16, PIPE=1: 2 edges.
- Throughput with out_ready held high: one block per BEATS+PIPE cycles.
- out_valid stays high until the handshake. out_data must not change while out_valid=1 and out_ready=0.
- Reset asserted mid-BUSY or in DONE: the block abandons the in-flight state, returns to reset values on the next edge, and produces no partial output.
- A mode change on in_dec has no effect on the block in progress.

## Structure
- Package aes_sbox_pkg holds:
  - AFF_FWD_C = 8'h63 and AFF_INV_C = 8'h05.
  - The rotl8 function and the forward/inverse affine functions.
  - The state enum (IDLE, BUSY, DONE).
- Sub-module sbox_lane(x, dec, y) is natural:
  - It wraps the existing GF_MULINV_8 with inverse-affine pre-mux and forward-affine post-mux.
  - For PIPE=1 the pipeline register sits inside the lane, with a lane-external valid tracked by the top level.
- The top level instantiates LANES copies of sbox_lane and a byte-group mux/demux indexed by the beat counter.

## Test plan
- FIPS-197 round-1 vector, forward, LANES=4, PIPE=0: in_data=193de3bea0f4e22b9ac68d2ae9f84808 → out_data=d42711aee0bf98f1b8b45de51e415230; out_valid exactly 4 edges after accept.
- Inverse on the above result, all LANES values, both PIPE values: d42711ae…5230 → 193de3be…4808; latency BEATS+PIPE.
- Corner bytes, forward: 00→63, 01→7c, 53→ed, ff→16. Inverse: 63→00, 16→ff. Check with all 16 bytes equal, LANES=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → out_data and out_valid stable, in_ready=0. Then raise out_ready together with in_valid → new block accepted that same edge, second result correct.
- Reset mid-BUSY at beat 2 (LANES=2) → next cycle out_valid=0, out_data=0, in_ready=1; a following block completes correctly.
- Exhaustive sweep: all 256 byte values in both modes through LANES=16, PIPE=1, compared against a software S-box table.
